led_blink_rx: RTL and testbench
===============================

Name: led_blink_rx

Overview:
- Receiving end of the LED blink interface: recovers the enable state and blink half-period from a blinking level driven by a counter-based blinker.
- The blinker toggles every CNT_MAX+1 clocks while enabled and holds its level when disabled.
- Sits on an input pin or inter-board wire, in front of control logic that needs the remote system_en.
- Synchronizes and glitch-filters the input, times the interval between edges, checks it against tolerance, and asserts system_en once the remote blinker is locked.

Parameters:
- CNT_MAX, 32'd24_999_999, terminal count of the remote blinker; expected half-period = CNT_MAX+1 clocks.
- TOL, 32'd1_250_000, allowed |measured − (CNT_MAX+1)| in clocks, inclusive.
- FILT_LEN, 16, consecutive stable samples required before the filtered level changes (≥1).
- LOCK_N, 2, consecutive in-tolerance measurements required to lock (≥1).
- TIMEOUT, 32'd50_000_000, clocks without an edge before declaring the link idle; must exceed CNT_MAX+1+TOL.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- blink_in  in  1  asynchronous blinking level from the remote blinker.
- led_level  out  1  filtered, synchronized level of blink_in.
- edge_pulse  out  1  one-cycle pulse on each filtered level change.
- half_period  out  32  last measured edge-to-edge interval in clocks; saturates at TIMEOUT.
- period_ok  out  1  last measurement within tolerance.
- system_en  out  1  recovered remote enable; high only in LOCK.

Behaviour:
- Reset: all outputs 0; internal FSM = IDLE; counters 0; filtered level 0; sync flops 0.
- Sync: 2-flop synchronizer on blink_in.
- Filter: the filtered level takes the synchronized value after FILT_LEN consecutive cycles that differ from the current filtered level. Any return to the current level restarts the run count.
- Latency: a stable input change produces edge_pulse 2+FILT_LEN clocks after the first clk edge that samples the new level. Every edge has the same latency, so intervals are preserved.
- Interval counter cnt:
  - Cleared to 0 in an edge_pulse cycle; otherwise increments.
  - Saturates at TIMEOUT.
  - On edge_pulse, measured = cnt+1, i.e. the number of clocks between consecutive edge_pulse assertions.
- On each edge_pulse outside IDLE:
  - half_period <= measured.
  - period_ok <= 1 if |measured − (CNT_MAX+1)| ≤ TOL, else 0.
  - Compare at 33-bit width to avoid wrap.
- FSM:
  - IDLE: first edge_pulse -> MEAS, good = 0. half_period and period_ok unchanged, because there is no reference edge.
  - MEAS, edge in tolerance: good++. If good reaches LOCK_N -> LOCK and system_en <= 1 in the same update.
  - MEAS, edge out of tolerance: good = 0, stay in MEAS.
  - LOCK, edge in tolerance: stay in LOCK.
  - LOCK, edge out of tolerance: -> MEAS, system_en <= 0, good = 0.
  - Any state except IDLE, cnt reaches TIMEOUT with no edge: -> IDLE, system_en <= 0, period_ok <= 0, half_period <= TIMEOUT.
- Simultaneous edge and timeout in one cycle: the edge wins, and it is measured as out of tolerance.
- Reset mid-operation: next cycle matches the reset state; no edge_pulse is generated from the pre-reset filtered level.
- system_en, period_ok and half_period are registered; they update the cycle after edge_pulse.

Optional Feature:
- Macro LED_BLINK_RX_FILTER_EN.
- Defined: glitch filter as described above.
- Undefined: the filter is removed and FILT_LEN is ignored. Filtered level = synchronizer output; edge latency = 2 clocks. All other behaviour is identical.

Test Plan (CNT_MAX=99, TOL=5, FILT_LEN=4, LOCK_N=2, TIMEOUT=300, filter enabled):
- Reset held 5 cycles, blink_in toggling -> all outputs 0 throughout; state IDLE on release.
- blink_in toggles every 100 clk -> edge_pulse every 100 clk; after the 2nd edge half_period=100, period_ok=1. system_en=1 the cycle after the 3rd edge_pulse and stays high.
- While locked, a 3-cycle glitch on blink_in -> no edge_pulse, outputs unchanged. A 4-cycle-stable level change -> edge_pulse 6 clocks after the change.
- Locked, one half-period of 110 -> half_period=110, period_ok=0, system_en=0. Returning to 100 -> relock (system_en=1) after 2 good edges. A half-period of 105 is accepted; 94 is rejected.
- Locked, blink_in frozen -> system_en falls 300 clocks after the last edge_pulse (+1 registered); half_period=300, period_ok=0, state IDLE.
- Rebuild with LED_BLINK_RX_FILTER_EN undefined -> edge latency 2 clocks, and a 3-cycle glitch produces two edge_pulses.

Source files
------------

// File: rtl/led_blink_rx.sv
// led_blink_rx: recovers the remote enable and blink half-period from a counter-based blinker's level.
// Define LED_BLINK_RX_FILTER_EN to insert the FILT_LEN-sample glitch filter after the synchronizer.
module led_blink_rx #(
    parameter logic [31:0] CNT_MAX  = 32'd24_999_999,
    parameter logic [31:0] TOL      = 32'd1_250_000,
    parameter int unsigned FILT_LEN = 16,
    parameter int unsigned LOCK_N   = 2,
    parameter logic [31:0] TIMEOUT  = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        blink_in,
    output logic        led_level,
    output logic        edge_pulse,
    output logic [31:0] half_period,
    output logic        period_ok,
    output logic        system_en
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEAS,
        ST_LOCK
    } state_t;

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        filt_level;
    logic        level_q, level_d;
    logic        edge_q, edge_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] half_q, half_d;
    logic        ok_q, ok_d;
    logic        en_q, en_d;
    logic [31:0] good_q, good_d;
    state_t      state_q, state_d;

    logic [32:0] cnt_inc;
    logic [32:0] target;
    logic [32:0] measured_wide;
    logic [32:0] deviation;
    logic [31:0] measured;
    logic        timeout_hit;
    logic        in_tol;

    always_comb begin
        sync1_d = blink_in;
        sync2_d = sync1_q;
    end

`ifdef LED_BLINK_RX_FILTER_EN
    logic        filt_q, filt_d;
    logic [31:0] run_q, run_d;

    // Any sample matching the current level restarts the run, so only a clean run of FILT_LEN flips it.
    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        if (sync2_q != filt_q) begin
            if (run_q + 32'd1 >= FILT_LEN) begin
                filt_d = sync2_q;
            end else begin
                run_d = run_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 1'b0;
            run_q  <= '0;
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    assign filt_level = filt_q;
`else
    logic [31:0] filt_len_unused;

    assign filt_len_unused = FILT_LEN;
    assign filt_level      = sync2_q;
`endif

    always_comb begin
        level_d = filt_level;
        edge_d  = filt_level != level_q;
    end

    // Interval measurement saturates at TIMEOUT; the compare runs at 33 bits so CNT_MAX+1 cannot wrap.
    always_comb begin
        cnt_inc       = {1'b0, cnt_q} + 33'd1;
        timeout_hit   = cnt_inc >= {1'b0, TIMEOUT};
        measured      = timeout_hit ? TIMEOUT : cnt_inc[31:0];
        cnt_d         = edge_q ? '0 : measured;
        target        = {1'b0, CNT_MAX} + 33'd1;
        measured_wide = {1'b0, measured};
        deviation     = (measured_wide >= target) ? (measured_wide - target)
                                                  : (target - measured_wide);
        in_tol        = (deviation <= {1'b0, TOL}) && !timeout_hit;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        half_d  = half_q;
        ok_d    = ok_q;
        en_d    = en_q;
        if (edge_q) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_MEAS;
                    good_d  = '0;
                end
                ST_MEAS: begin
                    half_d = measured;
                    ok_d   = in_tol;
                    if (in_tol) begin
                        good_d = good_q + 32'd1;
                        if (good_q + 32'd1 >= LOCK_N) begin
                            state_d = ST_LOCK;
                            en_d    = 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCK: begin
                    half_d = measured;
                    ok_d   = in_tol;
                    if (!in_tol) begin
                        state_d = ST_MEAS;
                        en_d    = 1'b0;
                        good_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    good_d  = '0;
                end
            endcase
        end else if (timeout_hit && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            ok_d    = 1'b0;
            half_d  = TIMEOUT;
            good_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
            half_q  <= '0;
            ok_q    <= 1'b0;
            en_q    <= 1'b0;
            good_q  <= '0;
            state_q <= ST_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            ok_q    <= ok_d;
            en_q    <= en_d;
            good_q  <= good_d;
            state_q <= state_d;
        end
    end

    assign led_level   = level_q;
    assign edge_pulse  = edge_q;
    assign half_period = half_q;
    assign period_ok   = ok_q;
    assign system_en   = en_q;

endmodule

// File: tb/tb_led_blink_rx.sv
// tb_led_blink_rx: directed stimulus with a scoreboard of expected edge_pulse cycles and an edge-level lock model.
// Works with LED_BLINK_RX_FILTER_EN defined or undefined.
module tb_led_blink_rx;

    localparam int CNT_MAX  = 99;
    localparam int TOL      = 5;
    localparam int FILT_LEN = 4;
    localparam int LOCK_N   = 2;
    localparam int TIMEOUT  = 300;

`ifdef LED_BLINK_RX_FILTER_EN
    localparam int EDGE_LAT = 2 + FILT_LEN;
    localparam int MIN_HOLD = FILT_LEN;
`else
    localparam int EDGE_LAT = 2;
    localparam int MIN_HOLD = 1;
`endif

    typedef struct {
        int   cyc;
        logic level;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        blink_in;
    logic        led_level;
    logic        edge_pulse;
    logic [31:0] half_period;
    logic        period_ok;
    logic        system_en;

    exp_t        sb[$];
    int          checks;
    int          errors;
    int          cyc;

    int          m_state;
    int          m_good;
    int          m_last;
    logic [31:0] m_half;
    logic        m_ok;
    logic        m_en;
    logic        m_level;
    logic        m_filt;
    logic        pend_pulse;
    int          pulse_cyc;

    led_blink_rx #(
        .CNT_MAX (32'(CNT_MAX)),
        .TOL     (32'(TOL)),
        .FILT_LEN(FILT_LEN),
        .LOCK_N  (LOCK_N),
        .TIMEOUT (32'(TIMEOUT))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .blink_in   (blink_in),
        .led_level  (led_level),
        .edge_pulse (edge_pulse),
        .half_period(half_period),
        .period_ok  (period_ok),
        .system_en  (system_en)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input logic exp_pulse);
        checks++;
        assert (edge_pulse === exp_pulse) else begin
            errors++;
            $error("[TB] FAIL edge_pulse cyc=%0d got=%b exp=%b", cyc, edge_pulse, exp_pulse);
        end
        checks++;
        assert (led_level === m_level) else begin
            errors++;
            $error("[TB] FAIL led_level cyc=%0d got=%b exp=%b", cyc, led_level, m_level);
        end
        checks++;
        assert (half_period === m_half) else begin
            errors++;
            $error("[TB] FAIL half_period cyc=%0d got=%0d exp=%0d", cyc, half_period, m_half);
        end
        checks++;
        assert (period_ok === m_ok) else begin
            errors++;
            $error("[TB] FAIL period_ok cyc=%0d got=%b exp=%b", cyc, period_ok, m_ok);
        end
        checks++;
        assert (system_en === m_en) else begin
            errors++;
            $error("[TB] FAIL system_en cyc=%0d got=%b exp=%b", cyc, system_en, m_en);
        end
    endtask

    // Advance one clock, fold the previous cycle's expected edge or timeout into the model, then compare.
    task automatic tick();
        logic exp_pulse;
        int   meas;
        logic good_edge;
        @(posedge clk);
        cyc++;
        #1;
        exp_pulse = 1'b0;
        if (rst) begin
            sb.delete();
            m_state    = 0;
            m_good     = 0;
            m_half     = '0;
            m_ok       = 1'b0;
            m_en       = 1'b0;
            m_level    = 1'b0;
            m_filt     = 1'b0;
            pend_pulse = 1'b0;
        end else begin
            if (pend_pulse) begin
                if (m_state == 0) begin
                    m_state = 1;
                    m_good  = 0;
                end else begin
                    meas = pulse_cyc - m_last;
                    if (meas > TIMEOUT) meas = TIMEOUT;
                    good_edge = (meas >= CNT_MAX + 1 - TOL) && (meas <= CNT_MAX + 1 + TOL)
                                && (meas < TIMEOUT);
                    m_half = 32'(meas);
                    m_ok   = good_edge;
                    if (m_state == 1) begin
                        if (good_edge) begin
                            m_good++;
                            if (m_good >= LOCK_N) begin
                                m_state = 2;
                                m_en    = 1'b1;
                            end
                        end else begin
                            m_good = 0;
                        end
                    end else if (!good_edge) begin
                        m_state = 1;
                        m_en    = 1'b0;
                        m_good  = 0;
                    end
                end
                m_last = pulse_cyc;
            end else if ((m_state != 0) && ((cyc - 1) - m_last >= TIMEOUT)) begin
                m_state = 0;
                m_en    = 1'b0;
                m_ok    = 1'b0;
                m_half  = 32'(TIMEOUT);
                m_good  = 0;
            end
            pend_pulse = 1'b0;
            if ((sb.size() > 0) && (sb[0].cyc == cyc)) begin
                exp_pulse  = 1'b1;
                m_level    = sb[0].level;
                pend_pulse = 1'b1;
                pulse_cyc  = cyc;
                void'(sb.pop_front());
            end
        end
        checkOutput(exp_pulse);
    endtask

    // Drive a level for a number of cycles; a change long enough to pass the filter schedules a pulse.
    task automatic applyStimulus(input logic v, input int hold);
        exp_t e;
        blink_in = v;
        if (!rst && (v != m_filt) && (hold >= MIN_HOLD)) begin
            e.cyc   = cyc + 1 + EDGE_LAT;
            e.level = v;
            sb.push_back(e);
            m_filt = v;
        end
        repeat (hold) tick();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rst        = 1'b1;
        blink_in   = 1'b0;
        m_state    = 0;
        m_good     = 0;
        m_last     = 0;
        m_half     = '0;
        m_ok       = 1'b0;
        m_en       = 1'b0;
        m_level    = 1'b0;
        m_filt     = 1'b0;
        pend_pulse = 1'b0;
        pulse_cyc  = 0;

        for (int i = 0; i < 5; i++) begin
            blink_in = ~blink_in;
            tick();
        end
        blink_in = 1'b0;
        rst      = 1'b0;
        applyStimulus(1'b0, 10);

        // Acquire lock on nominal 100-clock half-periods.
        applyStimulus(1'b1, 100);
        applyStimulus(1'b0, 100);
        applyStimulus(1'b1, 100);
        applyStimulus(1'b0, 100);
        applyStimulus(1'b1, 40);

        // 3-cycle glitch inside a half-period.
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 57);
        applyStimulus(1'b0, 100);

        // Long, short and boundary half-periods.
        applyStimulus(1'b1, 110);
        applyStimulus(1'b0, 100);
        applyStimulus(1'b1, 100);
        applyStimulus(1'b0, 105);
        applyStimulus(1'b1, 94);
        applyStimulus(1'b0, 95);
        applyStimulus(1'b1, 100);
        applyStimulus(1'b0, 100);

        // Minimum stable change, then relock.
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 96);
        applyStimulus(1'b1, 100);
        applyStimulus(1'b0, 100);
        applyStimulus(1'b1, 100);

        // Freeze the input until the link times out, then restart from idle.
        applyStimulus(1'b0, 330);
        applyStimulus(1'b1, 100);
        applyStimulus(1'b0, 100);
        applyStimulus(1'b1, 50);

        // Reset while locked with the filtered level high and the input now low.
        blink_in = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 30);

        applyStimulus(1'b1, 100);
        applyStimulus(1'b0, 100);
        applyStimulus(1'b1, 100);
        applyStimulus(1'b0, 20);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("[TB] FAIL pending_pulses got=%0d exp=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
